// File: rtl/arvi_arb_pkg.sv
// Shared types for the memory-port arbiter: FSM state, grant owner, and the I-cache byte enable.
// `XLEN defaults to 32 when the build does not supply it.
`ifndef XLEN
`define XLEN 32
`endif

package arvi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_IC = 2'd1,
    GNT_DM = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWNER_IC = 1'b0,
    OWNER_DM = 1'b1
  } arb_owner_e;

  // Refills always fetch a full word.
  localparam logic [3:0] IC_BE = 4'hF;

  // Round-robin choice; only meaningful when at least one side is eligible.
  function automatic arb_owner_e pick_owner(input logic ic_elig, input logic dm_elig,
                                            input arb_owner_e last);
    arb_owner_e owner;
    if (ic_elig && dm_elig) begin
      if (last == OWNER_IC) owner = OWNER_DM;
      else                  owner = OWNER_IC;
    end else if (dm_elig) begin
      owner = OWNER_DM;
    end else begin
      owner = OWNER_IC;
    end
    return owner;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the I-cache, the data side, the shared memory and the arbiter.
// slave is the arbiter's view; master is the requester/memory environment's view.
`ifndef XLEN
`define XLEN 32
`endif

interface mem_port_arbiter_if;
  logic               i_ic_req;
  logic [`XLEN-1:0]   i_ic_addr;
  logic [`XLEN-1:0]   o_ic_data;
  logic               o_ic_ready;

  logic               i_dm_rd;
  logic               i_dm_wr;
  logic [`XLEN-1:0]   i_dm_addr;
  logic [`XLEN-1:0]   i_dm_wdata;
  logic [3:0]         i_dm_be;
  logic [`XLEN-1:0]   o_dm_rdata;
  logic               o_dm_ready;

  logic               o_mem_req;
  logic               o_mem_we;
  logic [`XLEN-1:0]   o_mem_addr;
  logic [`XLEN-1:0]   o_mem_wdata;
  logic [3:0]         o_mem_be;
  logic [`XLEN-1:0]   i_mem_rdata;
  logic               i_mem_ready;

  logic               o_bus_err;

  modport slave (
    input  i_ic_req, i_ic_addr,
    output o_ic_data, o_ic_ready,
    input  i_dm_rd, i_dm_wr, i_dm_addr, i_dm_wdata, i_dm_be,
    output o_dm_rdata, o_dm_ready,
    output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be,
    input  i_mem_rdata, i_mem_ready,
    output o_bus_err
  );

  modport master (
    output i_ic_req, i_ic_addr,
    input  o_ic_data, o_ic_ready,
    output i_dm_rd, i_dm_wr, i_dm_addr, i_dm_wdata, i_dm_be,
    input  o_dm_rdata, o_dm_ready,
    input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be,
    output i_mem_rdata, i_mem_ready,
    input  o_bus_err
  );
endinterface

// File: rtl/mem_arb_watchdog.sv
// Memory-ready watchdog: counts grant cycles without i_mem_ready and flags the limit.
// Compiled only when ARVI_ARB_WATCHDOG_EN is defined.
`ifdef ARVI_ARB_WATCHDOG_EN

module mem_arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_start,
  input  logic i_active,
  input  logic i_mem_ready,
  output logic o_timeout
);
  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_start) begin
      cnt_d = '0;
    end else if (i_active && !i_mem_ready) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Fires in the cycle that would bring the count to TIMEOUT_CYCLES.
  assign o_timeout = i_active && !i_mem_ready && (cnt_q == LAST_CNT);

endmodule

`endif

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one registered memory port between I-cache refills and data accesses.
// Defining ARVI_ARB_WATCHDOG_EN adds a memory-ready watchdog that aborts stalled grants.
`ifndef XLEN
`define XLEN 32
`endif

module mem_port_arbiter
  import arvi_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              i_clk,
  input  logic              i_rst,
  mem_port_arbiter_if.slave bus
);

  arb_state_e       state_q, state_d;
  arb_owner_e       last_q, last_d;
  logic [`XLEN-1:0] mem_addr_q, mem_addr_d;
  logic [`XLEN-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]       mem_be_q, mem_be_d;
  logic             mem_we_q, mem_we_d;
  logic [`XLEN-1:0] ic_data_q, ic_data_d;
  logic [`XLEN-1:0] dm_rdata_q, dm_rdata_d;
  logic             ic_ready_q, ic_ready_d;
  logic             dm_ready_q, dm_ready_d;

  logic ic_elig, dm_elig, granted, grant_entry, done, timeout;

  // A side whose ready pulse is out this cycle sits out one arbitration round.
  assign ic_elig     = bus.i_ic_req && !ic_ready_q;
  assign dm_elig     = (bus.i_dm_rd || bus.i_dm_wr) && !dm_ready_q;
  assign granted     = (state_q != IDLE);
  assign grant_entry = (state_q == IDLE) && (state_d != IDLE);
  assign done        = granted && (bus.i_mem_ready || timeout);

`ifdef ARVI_ARB_WATCHDOG_EN
  logic bus_err_q, bus_err_d;

  mem_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_start     (grant_entry),
    .i_active    (granted),
    .i_mem_ready (bus.i_mem_ready),
    .o_timeout   (timeout)
  );

  assign bus_err_d = granted && timeout;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) bus_err_q <= 1'b0;
    else       bus_err_q <= bus_err_d;
  end

  assign bus.o_bus_err = bus_err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout            = 1'b0;
  assign bus.o_bus_err      = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      last_q  <= OWNER_IC;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (ic_elig || dm_elig) begin
          if (pick_owner(ic_elig, dm_elig, last_q) == OWNER_DM) begin
            state_d = GNT_DM;
            last_d  = OWNER_DM;
          end else begin
            state_d = GNT_IC;
            last_d  = OWNER_IC;
          end
        end
      end
      GNT_IC, GNT_DM: begin
        if (done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    mem_we_d    = mem_we_q;
    ic_data_d   = ic_data_q;
    dm_rdata_d  = dm_rdata_q;
    ic_ready_d  = 1'b0;
    dm_ready_d  = 1'b0;

    if (grant_entry) begin
      if (state_d == GNT_DM) begin
        mem_addr_d  = bus.i_dm_addr;
        mem_wdata_d = bus.i_dm_wdata;
        mem_be_d    = bus.i_dm_be;
        mem_we_d    = bus.i_dm_wr;
      end else begin
        mem_addr_d  = bus.i_ic_addr;
        mem_wdata_d = '0;
        mem_be_d    = IC_BE;
        mem_we_d    = 1'b0;
      end
    end

    // A watchdog abort completes the grant but leaves read data untouched.
    if (done) begin
      if (state_q == GNT_IC) begin
        ic_ready_d = 1'b1;
        if (bus.i_mem_ready) ic_data_d = bus.i_mem_rdata;
      end else begin
        dm_ready_d = 1'b1;
        if (bus.i_mem_ready && !mem_we_q) dm_rdata_d = bus.i_mem_rdata;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      mem_we_q    <= 1'b0;
      ic_data_q   <= '0;
      dm_rdata_q  <= '0;
      ic_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
    end else begin
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      mem_we_q    <= mem_we_d;
      ic_data_q   <= ic_data_d;
      dm_rdata_q  <= dm_rdata_d;
      ic_ready_q  <= ic_ready_d;
      dm_ready_q  <= dm_ready_d;
    end
  end

  // o_mem_req follows the state so reset drops it without waiting for a clock.
  assign bus.o_mem_req   = granted;
  assign bus.o_mem_we    = mem_we_q && granted;
  assign bus.o_mem_addr  = mem_addr_q;
  assign bus.o_mem_wdata = mem_wdata_q;
  assign bus.o_mem_be    = mem_be_q;
  assign bus.o_ic_data   = ic_data_q;
  assign bus.o_ic_ready  = ic_ready_q;
  assign bus.o_dm_rdata  = dm_rdata_q;
  assign bus.o_dm_ready  = dm_ready_q;

endmodule
